muldiv_seq: RTL and testbench

- Multi-cycle sequencer for RV32M unsigned multiply and divide: MUL, MULHU, DIVU and REMU.
- Uses no arithmetic of its own. Each iteration it drives one ADD or SUB through the shared combinational ALU and samples {C,R} in the same cycle.
- Sits beside the execute stage, which stalls on BUSY and takes RESULT on DONE.

---
 rtl/muldiv_pkg.sv | 7 +
 rtl/muldiv_seq_if.sv | 24 ++
 rtl/muldiv_step.sv | 31 +++
 rtl/muldiv_seq.sv | 67 ++++++
 tb/tb_muldiv_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the multiply/divide sequencer and its ALU.
package muldiv_pkg;
    typedef enum logic [1:0] {F_MUL, F_MULHU, F_DIVU, F_REMU} func_t;
    typedef enum logic {IDLE, CALC} state_t;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bus plus the borrowed-ALU operand/result wires.
interface muldiv_seq_if
    import muldiv_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int OPSIZE   = 4
);
    logic                start;
    func_t               func;
    logic [WORDSIZE-1:0] src_a;
    logic [WORDSIZE-1:0] src_b;
    logic                busy;
    logic                done;
    logic [WORDSIZE-1:0] result;
    logic [WORDSIZE-1:0] alu_a;
    logic [WORDSIZE-1:0] alu_b;
    logic [OPSIZE-1:0]   alu_op;
    logic [WORDSIZE-1:0] alu_r;
    logic                alu_c;
    modport master (output start, func, src_a, src_b, alu_r, alu_c,
                    input  busy, done, result, alu_a, alu_b, alu_op);
    modport slave  (input  start, func, src_a, src_b, alu_r, alu_c,
                    output busy, done, result, alu_a, alu_b, alu_op);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add or restoring-divide iteration built around the external ALU.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int OPSIZE   = 4
) (
    input  func_t               func_r,
    input  logic [WORDSIZE-1:0] hi,
    input  logic [WORDSIZE-1:0] lo,
    input  logic [WORDSIZE-1:0] opnd,
    input  logic [WORDSIZE-1:0] alu_r,
    input  logic                alu_c,
    output logic [WORDSIZE-1:0] alu_a,
    output logic [WORDSIZE-1:0] alu_b,
    output logic [OPSIZE-1:0]   alu_op,
    output logic [WORDSIZE-1:0] hi_n,
    output logic [WORDSIZE-1:0] lo_n
);
    logic                is_div, q;
    logic [WORDSIZE-1:0] s;
    assign is_div = func_r inside {F_DIVU, F_REMU};
    assign s      = {hi[WORDSIZE-2:0], lo[WORDSIZE-1]};
    // the bit shifted out of HI makes the trial subtraction succeed regardless of borrow
    assign q      = hi[WORDSIZE-1] | ~alu_c;
    assign alu_op = is_div ? OPSIZE'(OP_SUB) : OPSIZE'(OP_ADD);
    assign alu_a  = is_div ? s : hi;
    assign alu_b  = is_div ? opnd : (lo[0] ? opnd : '0);
    assign hi_n   = is_div ? (q ? alu_r : s) : {alu_c, alu_r[WORDSIZE-1:1]};
    assign lo_n   = is_div ? {lo[WORDSIZE-2:0], q} : {alu_r[0], lo[WORDSIZE-1:1]};
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M unsigned MUL/MULHU/DIVU/REMU sequencer driving a shared ALU.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int OPSIZE   = 4
) (
    input logic        clk,
    input logic        rst_n,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(WORDSIZE);
    state_t              state, state_n;
    func_t               func_r;
    logic [WORDSIZE-1:0] hi, lo, opnd, hi_n, lo_n, step_a, step_b, result;
    logic [OPSIZE-1:0]   step_op;
    logic [CW-1:0]       cnt;
    logic                busy, last, done;
    assign busy = state == CALC;
    assign last = busy && cnt == CW'(WORDSIZE - 1);
    muldiv_step #(.WORDSIZE(WORDSIZE), .OPSIZE(OPSIZE)) u_step (
        .func_r(func_r), .hi(hi), .lo(lo), .opnd(opnd),
        .alu_r(bus.alu_r), .alu_c(bus.alu_c),
        .alu_a(step_a), .alu_b(step_b), .alu_op(step_op),
        .hi_n(hi_n), .lo_n(lo_n)
    );
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
    assign bus.alu_a  = busy ? step_a : '0;
    assign bus.alu_b  = busy ? step_b : '0;
    assign bus.alu_op = busy ? step_op : '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    always_comb begin
        state_n = busy ? (last ? IDLE : CALC) : (bus.start ? CALC : IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_r <= F_MUL;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (!busy && bus.start) begin
                func_r <= bus.func;
                opnd   <= bus.src_b;
                cnt    <= '0;
                hi     <= '0;
                lo     <= bus.src_a;
            end else if (busy) begin
                hi  <= hi_n;
                lo  <= lo_n;
                cnt <= cnt + 1'b1;
                if (last) begin
                    done   <= 1'b1;
                    result <= func_r inside {F_MULHU, F_REMU} ? hi_n : lo_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq with a behavioural adder/subtractor ALU.
module tb_muldiv_seq;
    import muldiv_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [32:0] alu_sum;

    muldiv_seq_if bus ();
    muldiv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always_comb begin
        alu_sum = bus.alu_op == OP_ADD ? {1'b0, bus.alu_a} + {1'b0, bus.alu_b} :
                  bus.alu_op == OP_SUB ? {1'b0, bus.alu_a} - {1'b0, bus.alu_b} : 33'd0;
    end
    assign bus.alu_r = alu_sum[31:0];
    assign bus.alu_c = alu_sum[32];

    task automatic start_op(input func_t f, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        while (bus.busy) @(negedge clk);
        bus.start = 1'b1;
        bus.func  = f;
        bus.src_a = a;
        bus.src_b = b;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        bus.func  = func_t'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input string name, input bit chk_lat);
        int          n = 0;
        int          nb = 0;
        bit          seen = 0;
        bit          both = 0;
        logic [31:0] exp;
        while (n < 60 && !seen) begin
            @(negedge clk);
            n++;
            if (bus.done && bus.busy) both = 1;
            if (bus.done) seen = 1;
            else if (bus.busy) nb++;
        end
        exp = exp_q.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout: no done within %0d cycles", name, n);
        end else begin
            total++;
            if (bus.result !== exp) begin
                bad++;
                $display("FAIL %s result: got %h expected %h", name, bus.result, exp);
            end
            if (chk_lat) begin
                total += 2;
                if (n - 1 != 32) begin
                    bad++;
                    $display("FAIL %s latency: got %0d expected 32", name, n - 1);
                end
                if (nb != 32) begin
                    bad++;
                    $display("FAIL %s busy cycles: got %0d expected 32", name, nb);
                end
            end
        end
        total++;
        if (both) begin
            bad++;
            $display("FAIL %s done_and_busy: got 1 expected 0", name);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total += 4;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset done: got %b expected 0", bus.done); end
        if (bus.result !== 32'd0) begin bad++; $display("FAIL reset result: got %h expected 0", bus.result); end
        if (bus.alu_op !== 4'd0) begin bad++; $display("FAIL reset alu_op: got %h expected 0", bus.alu_op); end
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        start_op(F_MUL, 32'd7, 32'd6, 32'd42);
        wait_done("mul_7x6", 1'b1);
        start_op(F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_done("mul_ff", 1'b1);
        start_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_done("mulhu_ff", 1'b1);
    endtask

    task automatic test_div();
        start_op(F_DIVU, 32'd100, 32'd7, 32'd14);
        wait_done("divu_100_7", 1'b1);
        start_op(F_REMU, 32'd100, 32'd7, 32'd2);
        wait_done("remu_100_7", 1'b1);
        start_op(F_DIVU, 32'h8000_0000, 32'd1, 32'h8000_0000);
        wait_done("divu_msb_1", 1'b1);
        start_op(F_REMU, 32'h8000_0000, 32'd1, 32'd0);
        wait_done("remu_msb_1", 1'b1);
        start_op(F_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1);
        wait_done("divu_tbit", 1'b1);
        start_op(F_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF);
        wait_done("remu_tbit", 1'b1);
    endtask

    task automatic test_div_zero();
        start_op(F_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF);
        wait_done("divu_zero", 1'b1);
        start_op(F_REMU, 32'h1234, 32'd0, 32'h1234);
        wait_done("remu_zero", 1'b1);
    endtask

    task automatic test_busy_ignore();
        start_op(F_MUL, 32'd1000, 32'd1000, 32'd1000000);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.func  = F_DIVU;
        bus.src_a = 32'd9;
        bus.src_b = 32'd3;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_done("busy_ignore", 1'b0);
    endtask

    task automatic test_back_to_back();
        start_op(F_MULHU, 32'h8000_0000, 32'h0000_0010, 32'h0000_0008);
        wait_done("b2b_first", 1'b1);
        start_op(F_REMU, 32'd1001, 32'd10, 32'd1);
        wait_done("b2b_second", 1'b1);
    endtask

    task automatic test_reset_mid();
        int  n = 0;
        bit  seen = 0;
        bus.start = 1'b1;
        bus.func  = F_MUL;
        bus.src_a = 32'h1357;
        bus.src_b = 32'h2468;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total += 3;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL midreset done: got %b expected 0", bus.done); end
        if (bus.result !== 32'd0) begin bad++; $display("FAIL midreset result: got %h expected 0", bus.result); end
        @(negedge clk);
        rst_n = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL midreset late_done: got 1 expected 0"); end
        start_op(F_MUL, 32'd3, 32'd5, 32'd15);
        wait_done("mul_after_reset", 1'b1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.func  = F_MUL;
        bus.src_a = '0;
        bus.src_b = '0;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
